pixel_stream_scanner: RTL

Parametrised frame scanner between the raster stage and the display/stream sink. It generates pixel coordinates for the raster pipeline and captures the returned colour after a configurable latency. Captured pixels are buffered in a small FIFO and presented on a ready/valid stream with start-of-frame, end-of-line and end-of-frame tags. Per-pixel backpressure stalls coordinate issue instead of dropping pixels.

---
 rtl/pixel_stream_scanner.sv | 115 +++++++++++
 1 files changed

// File: rtl/pixel_stream_scanner.sv
// pixel_stream_scanner: raster coordinate scanner with latency-matched capture into a tagged ready/valid FIFO.
// Define SCAN_TINYVGA_PERMUTE_EN to reorder 6-bit pixels into TinyVGA pin order.
module pixel_stream_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int XW         = 10,
    parameter int YW         = 10,
    parameter int PIX_W      = 6,
    parameter int RASTER_LAT = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_req,
    output logic             scan_valid,
    output logic [XW-1:0]    scan_x,
    output logic [YW-1:0]    scan_y,
    input  logic [PIX_W-1:0] raster_rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy,
    output logic             frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state;
    logic [CW-1:0]    inflight, count;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [PIX_W+2:0] mem [FIFO_DEPTH];
    logic             issue, x_last, y_last, push, pop, done_now;
    logic [3:0]       iss_tag, cap_tag;
    logic [PIX_W-1:0] wr_rgb;

    assign x_last     = scan_x == XW'(H_ACTIVE - 1);
    assign y_last     = scan_y == YW'(V_ACTIVE - 1);
    // Credit: every issued pixel must already own a FIFO slot when it lands.
    assign issue      = state == SCAN && ({1'b0, inflight} + {1'b0, count} < (CW + 1)'(FIFO_DEPTH));
    assign scan_valid = issue;
    assign iss_tag    = {issue, scan_x == '0 && scan_y == '0, x_last, x_last && y_last};
    assign push       = cap_tag[3];
    assign out_valid  = count != '0;
    assign pop        = out_valid && out_ready;
    assign {out_data, out_sof, out_eol, out_eof} = out_valid ? mem[rd_ptr] : '0;
    assign busy       = state != IDLE;
    assign done_now   = state == DRAIN && inflight == '0 && count == CW'(pop);

    generate
        if (RASTER_LAT == 0) begin : g_no_pipe
            assign cap_tag = iss_tag;
        end else begin : g_pipe
            logic [3:0] pipe [RASTER_LAT];
            always_ff @(posedge clk) begin
                for (int i = 0; i < RASTER_LAT; i++)
                    pipe[i] <= reset ? 4'b0 : (i == 0 ? iss_tag : pipe[i == 0 ? 0 : i - 1]);
            end
            assign cap_tag = pipe[RASTER_LAT-1];
        end
`ifdef SCAN_TINYVGA_PERMUTE_EN
        if (PIX_W != 6) begin : g_bad_width
            $error("SCAN_TINYVGA_PERMUTE_EN requires PIX_W == 6");
            assign wr_rgb = raster_rgb;
        end else begin : g_permute
            assign wr_rgb = {raster_rgb[4], raster_rgb[2], raster_rgb[0],
                             raster_rgb[5], raster_rgb[3], raster_rgb[1]};
        end
`else
        assign wr_rgb = raster_rgb;
`endif
    endgenerate

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {wr_rgb, cap_tag[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            scan_x     <= '0;
            scan_y     <= '0;
            inflight   <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_now;
            inflight   <= inflight + CW'(issue) - CW'(push);
            count      <= count + CW'(push) - CW'(pop);
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            case (state)
                IDLE: if (frame_req) begin
                    state  <= SCAN;
                    scan_x <= '0;
                    scan_y <= '0;
                end
                SCAN: if (issue) begin
                    scan_x <= x_last ? '0 : scan_x + XW'(1);
                    scan_y <= x_last ? (y_last ? '0 : scan_y + YW'(1)) : scan_y;
                    if (x_last && y_last) state <= DRAIN;
                end
                DRAIN: if (done_now) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && count == CW'(FIFO_DEPTH)));
endmodule
